// File: rtl/send_un_script_data.sv
// Outbound UART command sender: queues {payload, type} command bytes in a small FIFO
// and serialises them as 8N1, LSB first, with back-to-back frames when the queue is non-empty.
module send_un_script_data #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cmd_valid,
  input  logic [1:0]                    i_cmd_type,
  input  logic [5:0]                    i_cmd_payload,
  output logic                          o_cmd_ready,
  output logic                          o_tx,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(DIV - 2);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_bit_end;

  // Ready is judged on the pre-pop count, so a full queue refuses even when a pop coincides.
  assign w_full      = (r_count == FULL_CNT);
  assign w_push      = i_cmd_valid && !w_full;
  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign w_pop       = (r_count != '0) &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign o_cmd_ready  = !w_full;
  assign o_tx         = r_tx;
  assign o_tx_busy    = r_busy;
  assign o_tx_done    = r_done;
  assign o_fifo_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_cmd_payload, i_cmd_type};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Registered so the pulse lands in the final clock of the stop bit.
      r_done <= (r_state == S_STOP) && (r_baud == BAUD_PRE);
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_send_un_script_data.sv
// Bench for send_un_script_data: directed scenarios plus random traffic, checked each cycle
// against a frame-timeline model of the queue and the expected serial waveform.
module tb_send_un_script_data;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'b00;
  logic [5:0] cmd_payload = 6'b0;
  logic       cmd_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  send_un_script_data #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .i_cmd_type   (cmd_type),
    .i_cmd_payload(cmd_payload),
    .o_cmd_ready  (cmd_ready),
    .o_tx         (tx),
    .o_tx_busy    (tx_busy),
    .o_tx_done    (tx_done),
    .o_fifo_count (fifo_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of waiting bytes plus the position inside the frame on the wire.
  int         m_q[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;

  // Receiver on the DUT pin, sampling mid-bit.
  int         rx_q[$];
  bit         rx_on = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte = 8'h00;
  int         n_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic exp_tx();
    if (!m_active) return 1'b1;
    if (m_t < DIV) return 1'b0;
    if (m_t < 9 * DIV) return m_cur[(m_t - DIV) / DIV];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_t      = 0;
    rx_on    = 1'b0;
  endtask

  task automatic tick();
    bit         pop;
    bit         push;
    logic [7:0] b;
    if (rst) begin
      model_reset();
    end else begin
      pop  = (m_q.size() != 0) && (!m_active || (m_t == FRAME - 1));
      push = cmd_valid && (m_q.size() < DEPTH);
      b    = {cmd_payload, cmd_type};
      if (m_active) begin
        if (m_t == FRAME - 1) m_active = 1'b0;
        else m_t++;
      end
      if (pop) begin
        m_cur    = 8'(m_q.pop_front());
        m_active = 1'b1;
        m_t      = 0;
      end
      if (push) m_q.push_back(int'(b));
    end
    @(posedge clk);
    #1;
    check("tx", tx, exp_tx());
    check("tx_busy", tx_busy, m_active);
    check("tx_done", tx_done, m_active && (m_t == FRAME - 1));
    check("fifo_count", fifo_count, m_q.size());
    check("cmd_ready", cmd_ready, m_q.size() < DEPTH);
    if (tx_done) n_done++;
    if (tx_busy && !rst) begin
      if (!rx_on) begin
        rx_on = 1'b1;
        rx_t  = 0;
      end
      if (rx_t >= DIV + DIV / 2 && rx_t < 9 * DIV && ((rx_t - DIV - DIV / 2) % DIV) == 0)
        rx_byte[(rx_t - DIV) / DIV] = tx;
      rx_t++;
      if (tx_done) begin
        rx_q.push_back(int'(rx_byte));
        rx_on = 1'b0;
      end
    end else begin
      rx_on = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    cmd_valid = 1'b1;
    {cmd_payload, cmd_type} = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while ((tx_busy || fifo_count != 0) && n < bound) begin
      tick();
      n++;
    end
    check(tag, n < bound, 1'b1);
    tick();
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (!tx_done && n < bound) begin
      tick();
      n++;
    end
    check(tag, tx_done, 1'b1);
  endtask

  task automatic check_rx(input string tag, input int idx, input int exp_v);
    check(tag, (idx < rx_q.size()) ? rx_q[idx] : -1, exp_v);
  endtask

  initial begin
    int         d0;
    int         k;
    logic [7:0] bytes [4];

    // Reset state, checked asynchronously before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ready", cmd_ready, 1'b1);
    model_reset();
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    // Single command 0x15 and its exact frame timing.
    rx_q.delete();
    d0 = n_done;
    push({6'b000101, 2'b01});
    tick();
    check("t1_start_low", tx, 1'b0);
    k = 0;
    while (!tx_done && k < 300) begin
      tick();
      k++;
    end
    check("t1_done_at_160", k, 159);
    tick();
    check("t1_busy_drop", tx_busy, 1'b0);
    drain("t1_drain", 400);
    check("t1_frames", n_done - d0, 1);
    check_rx("t1_byte", 0, 8'h15);

    // Four back-to-back commands.
    rx_q.delete();
    d0 = n_done;
    for (int i = 0; i < 4; i++) begin
      bytes[i] = 8'($urandom);
      push(bytes[i]);
    end
    check("t2_count", fifo_count, 3'd3);
    drain("t2_drain", 1000);
    check("t2_frames", n_done - d0, 4);
    for (int i = 0; i < 4; i++) check_rx("t2_byte", i, int'(bytes[i]));
    check("t2_count_end", fifo_count, 3'd0);

    // Overflow: eight consecutive requests, only five survive.
    rx_q.delete();
    d0 = n_done;
    cmd_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      {cmd_payload, cmd_type} = 8'(i);
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_ready_low", cmd_ready, 1'b0);
    drain("t3_drain", 1200);
    check("t3_frames", n_done - d0, 5);
    for (int i = 0; i < 5; i++) check_rx("t3_byte", i, i + 1);

    // Full FIFO while the stop bit ends with cmd_valid held high.
    push(8'hA1);
    tick();
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    push(8'hA5);
    check("t4_full", fifo_count, 3'd4);
    cmd_valid = 1'b1;
    {cmd_payload, cmd_type} = 8'hA6;
    wait_done("t4_done_seen", 200);
    check("t4_count_4", fifo_count, 3'd4);
    tick();
    check("t4_count_3", fifo_count, 3'd3);
    tick();
    check("t4_count_4b", fifo_count, 3'd4);
    cmd_valid = 1'b0;
    drain("t4_drain", 1200);

    // Reset during data bit 3 with two commands queued.
    push(8'h31);
    push(8'h32);
    push(8'h33);
    repeat (70) tick();
    check("t5_midframe", tx_busy, 1'b1);
    check("t5_queued", fifo_count, 3'd2);
    #2 rst = 1'b1;
    #1;
    check("t5_tx", tx, 1'b1);
    check("t5_busy", tx_busy, 1'b0);
    check("t5_count", fifo_count, 3'd0);
    model_reset();
    tick();
    tick();
    #2 rst = 1'b0;
    d0 = n_done;
    repeat (400) tick();
    check("t5_no_frames", n_done - d0, 0);

    // Push on the very edge the stop bit completes with an empty FIFO.
    rx_q.delete();
    push(8'h5A);
    wait_done("t6_done_seen", 200);
    cmd_valid = 1'b1;
    {cmd_payload, cmd_type} = 8'hC3;
    tick();
    cmd_valid = 1'b0;
    check("t6_idle", tx_busy, 1'b0);
    check("t6_count", fifo_count, 3'd1);
    tick();
    check("t6_busy", tx_busy, 1'b1);
    check("t6_start", tx, 1'b0);
    drain("t6_drain", 400);
    check_rx("t6_byte_a", 0, 8'h5A);
    check_rx("t6_byte_b", 1, 8'hC3);

    // Random sparse and bursty traffic against the model.
    repeat (3000) begin
      cmd_valid = ($urandom_range(0, 39) < 2);
      {cmd_payload, cmd_type} = 8'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    drain("rand_drain", 2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
